sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Single-port arbiter-free controller for the board's 1M x 16 asynchronous SRAM.
- Responds to word read/write requests from one effect block (for example the delay line) over a req/ack handshake.
- Generates glitch-free, registered CE_N/OE_N/WE_N/UB_N/LB_N strobes, owns the SRAM_DQ tri-state and captures read data.
- Effect blocks never touch the SRAM pins directly; they issue requests here instead.

Parameters:
READ_WAIT, 2, cycles OE_N/CE_N held low before DQ is sampled; legal 1..15
WRITE_WAIT, 2, cycles WE_N held low; legal 1..15

Ports:
CLK  input  1  system clock (50 MHz)
RESET_N  input  1  asynchronous, active-low reset
req  input  1  client request; addr/we/wdata must be valid while req=1
we  input  1  1 = write, 0 = read
addr  input  20  word address
wdata  input  16  write data
ack  output  1  one-cycle pulse: transaction complete
rdata  output  16  read data; valid when ack=1 after a read, held until the next read completes
busy  output  1  1 from acceptance until the cycle before ack
SRAM_ADDR  output  20  SRAM address
SRAM_DQ  inout  16  SRAM data bus
SRAM_CE_N  output  1  chip enable
SRAM_OE_N  output  1  output enable
SRAM_WE_N  output  1  write enable
SRAM_UB_N  output  1  upper byte enable; always equals SRAM_CE_N
SRAM_LB_N  output  1  lower byte enable; always equals SRAM_CE_N

Behaviour:
- All outputs are registered. There is no combinational path from req to any SRAM pin.
- Async reset (RESET_N=0) values: state IDLE, CE_N=OE_N=WE_N=UB_N=LB_N=1, SRAM_DQ hi-Z, SRAM_ADDR=0, ack=0, busy=0, rdata=0, wait counter=0.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE:
  - All strobes high, DQ hi-Z.
  - If req=1 and ack=0 at a clock edge: latch addr into SRAM_ADDR, latch wdata, set busy=1, load counter.
  - we=0 goes to RD; we=1 goes to WR_SETUP.
  - req is ignored while ack=1. This forces at least one idle cycle between transactions and prevents re-accepting the same request.
- RD (READ_WAIT cycles):
  - CE_N=0, OE_N=0, WE_N=1, DQ hi-Z.
  - At the edge ending the last RD cycle: rdata<=SRAM_DQ, ack<=1, busy<=0, go to IDLE.
- WR_SETUP (1 cycle): CE_N=0, OE_N=1, WE_N=1, DQ driven with latched wdata.
- WR_PULSE (WRITE_WAIT cycles): CE_N=0, WE_N=0, DQ driven.
- WR_HOLD (1 cycle):
  - CE_N=0, WE_N=1, DQ still driven (data hold).
  - At exit: ack<=1, busy<=0, go to IDLE.
- Latency, with the request sampled at the edge ending cycle 0:
  - Read: ack high in cycle READ_WAIT+1.
  - Write: ack high in cycle WRITE_WAIT+3.
- SRAM_ADDR changes only on acceptance and is stable for the whole transaction, including WR_HOLD.
- Bus turnaround:
  - DQ is driven only in WR_* states. OE_N is 1 in every WR_* state.
  - At least one IDLE cycle with OE_N=1 and DQ hi-Z always separates a read from a following write.
- Request fields are latched at acceptance. Deasserting req, or changing addr/wdata/we, afterwards has no effect; the transaction completes and ack is still issued.
- rdata is unchanged by writes.
- Reset mid-transaction:
  - Strobes go high and DQ goes hi-Z immediately (asynchronously). No ack is issued.
  - Contents at the interrupted write address are undefined; all other addresses are unaffected.
- Counter: 4 bits, loaded with the parameter value minus 1, decrements to 0.
- A parameter value of 0 is illegal; flag it with an elaboration-time check.

Test Plan:
- Reset: hold RESET_N=0 mid-cycle with req=1 -> all strobes=1, DQ hi-Z, ack=0, busy=0, SRAM_ADDR=0, rdata=0, with no clock edge required.
- Write 0xBEEF to address 0x00ABC, defaults -> cycle 1 CE_N=0/WE_N=1 with DQ=0xBEEF; cycles 2-3 WE_N=0; cycle 4 WE_N=1 with DQ still 0xBEEF; ack=1 in cycle 5 only. SRAM model holds 0xBEEF.
- Read back 0x00ABC -> OE_N=0 in cycles 1-2, ack=1 in cycle 3 with rdata=0xBEEF; rdata still 0xBEEF after a subsequent write of 0x1234 elsewhere.
- Back-to-back: req held high across a read then a write -> ack cycle ignores req; there is at least one cycle where OE_N=1 and DQ is hi-Z before DQ is driven; the model reports no bus contention.
- req pulsed for one cycle with a write of 0x5555 to 0xFFFFF, then addr changed to 0x00000 -> write lands at 0xFFFFF, ack issued once.
- Assert RESET_N=0 during WR_PULSE -> WE_N=1 immediately, no ack; after release, a read of a different address returns its prior contents. READ_WAIT=1 build: read ack in cycle 2.

Source files
------------

// File: rtl/sram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_ctrl : req/ack word controller for a 1M x 16 asynchronous SRAM     |
// | Rev 1.0   : initial release                                              |
// +--------------------------------------------------------------------------+
module sram_ctrl #(
   parameter int READ_WAIT  = 2,
   parameter int WRITE_WAIT = 2
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        req,
   input  logic        we,
   input  logic [19:0] addr,
   input  logic [15:0] wdata,
   output logic        ack,
   output logic [15:0] rdata,
   output logic        busy,
   output logic [19:0] SRAM_ADDR,
   inout  wire  [15:0] SRAM_DQ,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   localparam logic [2:0] c_idle     = 3'd0;
   localparam logic [2:0] c_rd       = 3'd1;
   localparam logic [2:0] c_wr_setup = 3'd2;
   localparam logic [2:0] c_wr_pulse = 3'd3;
   localparam logic [2:0] c_wr_hold  = 3'd4;

   localparam logic [3:0] c_rd_load = 4'(READ_WAIT - 1);
   localparam logic [3:0] c_wr_load = 4'(WRITE_WAIT - 1);

   generate
      if (READ_WAIT < 1 || READ_WAIT > 15) begin : g_bad_read_wait
         $error("sram_ctrl: READ_WAIT must be in 1..15");
      end
      if (WRITE_WAIT < 1 || WRITE_WAIT > 15) begin : g_bad_write_wait
         $error("sram_ctrl: WRITE_WAIT must be in 1..15");
      end
   endgenerate

   logic [2:0]  r_state;
   logic [3:0]  r_cnt;
   logic [19:0] r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_rdata;
   logic        r_ack;
   logic        r_busy;
   logic        r_ce_n;
   logic        r_oe_n;
   logic        r_we_n;
   logic        r_dq_oe;

   logic [2:0]  w_state_nxt;
   logic [3:0]  w_cnt_nxt;
   logic        w_accept;
   logic        w_done;
   logic        w_ce_n_nxt;
   logic        w_oe_n_nxt;
   logic        w_we_n_nxt;
   logic        w_dq_oe_nxt;

   // State and all pin-facing registers; reset drops every strobe at once.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= c_idle;
         r_cnt   <= 4'd0;
         r_addr  <= 20'd0;
         r_wdata <= 16'd0;
         r_rdata <= 16'd0;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
         r_ce_n  <= 1'b1;
         r_oe_n  <= 1'b1;
         r_we_n  <= 1'b1;
         r_dq_oe <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ack   <= w_done;
         r_ce_n  <= w_ce_n_nxt;
         r_oe_n  <= w_oe_n_nxt;
         r_we_n  <= w_we_n_nxt;
         r_dq_oe <= w_dq_oe_nxt;
         if (w_accept) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_busy  <= 1'b1;
         end else if (w_done) begin
            r_busy  <= 1'b0;
         end
         if (w_done && r_state == c_rd) begin
            r_rdata <= SRAM_DQ;
         end
      end
   end

   // ack blocks acceptance so a held req cannot be taken twice.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         c_idle: begin
            if (req && !r_ack) begin
               w_accept    = 1'b1;
               w_state_nxt = we ? c_wr_setup : c_rd;
               w_cnt_nxt   = we ? c_wr_load : c_rd_load;
            end
         end
         c_rd: begin
            if (r_cnt == 4'd0) begin
               w_done      = 1'b1;
               w_state_nxt = c_idle;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         c_wr_setup: begin
            w_state_nxt = c_wr_pulse;
         end
         c_wr_pulse: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = c_wr_hold;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         c_wr_hold: begin
            w_done      = 1'b1;
            w_state_nxt = c_idle;
         end
         default: begin
            w_state_nxt = c_idle;
         end
      endcase
   end

   // Strobes are decoded from the next state so they leave a flop cleanly.
   always_comb begin
      w_ce_n_nxt  = 1'b1;
      w_oe_n_nxt  = 1'b1;
      w_we_n_nxt  = 1'b1;
      w_dq_oe_nxt = 1'b0;
      case (w_state_nxt)
         c_rd: begin
            w_ce_n_nxt = 1'b0;
            w_oe_n_nxt = 1'b0;
         end
         c_wr_setup, c_wr_hold: begin
            w_ce_n_nxt  = 1'b0;
            w_dq_oe_nxt = 1'b1;
         end
         c_wr_pulse: begin
            w_ce_n_nxt  = 1'b0;
            w_we_n_nxt  = 1'b0;
            w_dq_oe_nxt = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign SRAM_DQ   = r_dq_oe ? r_wdata : 16'bz;
   assign SRAM_ADDR = r_addr;
   assign SRAM_CE_N = r_ce_n;
   assign SRAM_OE_N = r_oe_n;
   assign SRAM_WE_N = r_we_n;
   assign SRAM_UB_N = r_ce_n;
   assign SRAM_LB_N = r_ce_n;
   assign ack       = r_ack;
   assign busy      = r_busy;
   assign rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_ctrl : table-driven bench with SRAM model and ack scoreboard    |
// | Rev 1.0      : initial release                                           |
// +--------------------------------------------------------------------------+
module tb_sram_ctrl;

   localparam int RW = 2;
   localparam int WW = 2;

   logic        CLK     = 1'b0;
   logic        RESET_N = 1'b1;
   logic        req     = 1'b0;
   logic        we      = 1'b0;
   logic [19:0] addr    = 20'd0;
   logic [15:0] wdata   = 16'd0;
   logic        ack, busy;
   logic [15:0] rdata;
   logic [19:0] SRAM_ADDR;
   wire  [15:0] SRAM_DQ;
   logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

   // second controller built with READ_WAIT=1
   logic        req1 = 1'b0;
   logic        ack1, busy1;
   logic [15:0] rdata1;
   logic [19:0] sram_addr1;
   wire  [15:0] dq1;
   logic        ce1_n, oe1_n, we1_n, ub1_n, lb1_n;

   always #5 CLK = ~CLK;

   sram_ctrl #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .busy(busy), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
      .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
      .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N));

   sram_ctrl #(.READ_WAIT(1), .WRITE_WAIT(WW)) dut_rw1 (
      .CLK(CLK), .RESET_N(RESET_N), .req(req1), .we(1'b0), .addr(20'h00042), .wdata(16'h0000),
      .ack(ack1), .rdata(rdata1), .busy(busy1), .SRAM_ADDR(sram_addr1), .SRAM_DQ(dq1),
      .SRAM_CE_N(ce1_n), .SRAM_OE_N(oe1_n), .SRAM_WE_N(we1_n),
      .SRAM_UB_N(ub1_n), .SRAM_LB_N(lb1_n));

   assign dq1 = (!ce1_n && !oe1_n) ? 16'hC3C3 : 16'bz;

   // ---------------- SRAM model ----------------
   logic [15:0] mem [bit [19:0]];
   int          mem_gen = 0;
   logic        model_drv = 1'b0;
   logic [15:0] model_q   = 16'd0;

   initial forever begin
      model_drv = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
      model_q   = mem.exists(SRAM_ADDR) ? mem[SRAM_ADDR] : 16'hDEAD;
      @(SRAM_ADDR or SRAM_CE_N or SRAM_OE_N or SRAM_WE_N or mem_gen);
   end

   assign SRAM_DQ = model_drv ? model_q : 16'bz;

   // ---------------- checking ----------------
   typedef struct {
      bit          we;
      logic [15:0] rd;
   } sb_t;

   sb_t         sb[$];
   int          n_vec   = 0;
   int          n_err   = 0;
   int          acks    = 0;
   logic        prev_ack = 1'b0;
   logic [15:0] last_rd = 16'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_rel(input string name, input logic [15:0] v);
      n_vec++;
      if (!((v === 16'h0000) || (v === 16'hzzzz))) begin
         n_err++;
         $display("FAIL %s: actual %h required hi-Z at %0t", name, v, $time);
      end
   endtask

   task automatic tick;
      @(negedge CLK);
      #1;
   endtask

   // Monitor: SRAM writes, contention, ack scoreboard.
   initial begin : mon
      sb_t e;
      forever begin
         @(negedge CLK);
         if (!RESET_N) begin
            prev_ack = 1'b0;
         end else begin
            if (model_drv) chk("contention", SRAM_DQ, model_q);
            if (!SRAM_CE_N && !SRAM_WE_N) begin
               mem[SRAM_ADDR] = SRAM_DQ;
               mem_gen++;
            end
            if (ack === 1'b1) begin
               acks++;
               chk("ack_width", prev_ack, 0);
               if (sb.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_ack: actual ack=1 required no ack at %0t", $time);
               end else begin
                  e = sb.pop_front();
                  if (!e.we) begin
                     chk("rdata_read", rdata, e.rd);
                     last_rd = e.rd;
                  end else begin
                     chk("rdata_kept", rdata, last_rd);
                  end
               end
            end
            prev_ack = ack;
         end
      end
   end

   // One transaction with a cycle-by-cycle check from acceptance to ack.
   task automatic txn(input bit w, input logic [19:0] a, input logic [15:0] d,
                      input logic [15:0] rd_exp, input bit drop_req, input bit chained);
      int   last;
      int   k;
      logic ce, oe, wen, ak, bz;
      if (!chained) begin
         k = 0;
         while ((busy !== 1'b0 || ack !== 1'b0) && k < 50) begin
            tick();
            k++;
         end
         if (k == 50) chk("idle_timeout", 1, 0);
      end
      req = 1'b1; we = w; addr = a; wdata = d;
      if (chained) begin
         tick();
         chk("gap_ack_oe_ce", {ack, SRAM_OE_N, SRAM_CE_N}, 3'b011);
         chk_rel("gap_dq", SRAM_DQ);
      end
      sb.push_back('{w, rd_exp});
      last = w ? WW + 3 : RW + 1;
      for (int c = 1; c <= last; c++) begin
         tick();
         if (c == 1 && drop_req) begin
            req = 1'b0; we = ~w; addr = ~a; wdata = ~d;
         end
         ce  = (c == last);
         oe  = w || (c == last);
         wen = !(w && c >= 2 && c <= WW + 1);
         ak  = (c == last);
         bz  = (c != last);
         chk($sformatf("strobes_%s_c%0d", w ? "wr" : "rd", c),
             {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, ack, busy},
             {ce, oe, wen, ce, ce, ak, bz});
         if (c < last) begin
            chk($sformatf("addr_c%0d", c), SRAM_ADDR, a);
            chk($sformatf("dq_c%0d", c), SRAM_DQ, w ? d : rd_exp);
         end else begin
            chk_rel("dq_at_ack", SRAM_DQ);
         end
      end
      if (w) chk("mem_written", mem.exists(a) ? mem[a] : 16'hDEAD, d);
   endtask

   typedef struct {
      bit          we;
      logic [19:0] addr;
      logic [15:0] wdata;
      logic [15:0] rd_exp;
      bit          drop;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int base_acks;
      tbl[0] = '{1'b1, 20'h00ABC, 16'hBEEF, 16'h0000, 1'b1};
      tbl[1] = '{1'b0, 20'h00ABC, 16'h0000, 16'hBEEF, 1'b1};
      tbl[2] = '{1'b1, 20'h12345, 16'h1234, 16'h0000, 1'b1};
      tbl[3] = '{1'b0, 20'h00300, 16'h0000, 16'h5A5A, 1'b1};
      tbl[4] = '{1'b0, 20'h12345, 16'h0000, 16'h1234, 1'b0};
      tbl[5] = '{1'b1, 20'h00ABD, 16'hCAFE, 16'h0000, 1'b1};
      tbl[6] = '{1'b1, 20'hFFFFF, 16'h5555, 16'h0000, 1'b1};
      tbl[7] = '{1'b0, 20'hFFFFF, 16'h0000, 16'h5555, 1'b1};
      mem[20'h00200] = 16'hA5A5;
      mem[20'h00300] = 16'h5A5A;

      // asynchronous reset with req high, before any clock edge
      req = 1'b1; we = 1'b1; addr = 20'h12345; wdata = 16'hFFFF;
      #1 RESET_N = 1'b0;
      #1;
      chk("por_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, ack, busy}, 7'b1111100);
      chk_rel("por_dq", SRAM_DQ);
      chk("por_addr", SRAM_ADDR, 0);
      chk("por_rdata", rdata, 0);
      repeat (2) @(negedge CLK);
      #1;
      req = 1'b0;
      RESET_N = 1'b1;

      for (int i = 0; i < 8; i++) begin
         txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rd_exp, tbl[i].drop,
             (i > 0) && !tbl[i-1].drop);
      end
      chk("addr_change_ignored", mem.exists(20'h00000), 0);

      // reset in the middle of the write pulse
      txn(1'b0, 20'h00200, 16'h0000, 16'hA5A5, 1'b1, 1'b0);
      tick();
      base_acks = acks;
      req = 1'b1; we = 1'b1; addr = 20'h00100; wdata = 16'h7777;
      tick();
      req = 1'b0;
      tick();
      chk("pulse_we_low", SRAM_WE_N, 0);
      #2 RESET_N = 1'b0;
      #1;
      chk("midrst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, ack, busy}, 7'b1111100);
      chk_rel("midrst_dq", SRAM_DQ);
      chk("midrst_addr", SRAM_ADDR, 0);
      chk("midrst_rdata", rdata, 0);
      last_rd = 16'd0;
      req = 1'b1;
      repeat (3) tick();
      req = 1'b0;
      RESET_N = 1'b1;
      repeat (3) tick();
      chk("no_ack_after_reset", acks, base_acks);
      txn(1'b0, 20'h00200, 16'h0000, 16'hA5A5, 1'b1, 1'b0);

      // READ_WAIT=1 build: ack in cycle 2
      tick();
      req1 = 1'b1;
      tick();
      req1 = 1'b0;
      chk("rw1_c1", {ack1, oe1_n, busy1}, 3'b001);
      tick();
      chk("rw1_c2", {ack1, oe1_n, busy1}, 3'b110);
      chk("rw1_rdata", rdata1, 16'hC3C3);
      tick();
      chk("rw1_c3_ack", ack1, 0);

      repeat (3) tick();
      chk("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
